apb_timer_regbank: RTL and testbench
====================================

Name: apb_timer_regbank

Overview:
- Downstream APB peripheral behind the AHB-to-APB bridge. It consumes Pselx, Penable, Pwrite, Paddr and Pwdata, and returns Prdata.
- Contains a memory-mapped register bank, a reloadable down-counter timer with an interrupt, and a protocol-error monitor.
- The bridge's APB port has no PREADY or PSLVERR, so the block always completes in the fixed two-phase APB timing (zero wait states).

Parameters:
- SEL_IDX, 0, index of the Pselx bit that selects this peripheral (0..2).
- NUM_SCRATCH, 8, number of 32-bit general-purpose scratch registers (1..12).
- CNT_W, 32, width of LOAD and COUNT; upper bits read as 0 when less than 32.

Ports:
- Hclk  in  1  system clock, rising edge.
- Hresetn  in  1  asynchronous active-low reset.
- Pselx  in  3  APB slave selects; only bit SEL_IDX is used.
- Penable  in  1  APB enable (ACCESS phase).
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  32  APB address; only Paddr[5:2] is decoded.
- Pwdata  in  32  APB write data.
- Prdata  out  32  APB read data, registered.
- irq  out  1  level interrupt, registered.

Behaviour:
- Reset (async, Hresetn=0):
  - Prdata=0, irq=0, FSM=IDLE.
  - CTRL=0, STATUS=0, LOAD=0, COUNT=0, all scratch registers = 0.
- sel = Pselx[SEL_IDX].
- APB FSM states: IDLE, SETUP, ACCESS.
  - IDLE: sel & !Penable -> SETUP. sel & Penable -> set STATUS.PERR, stay IDLE.
  - SETUP: sel & Penable -> ACCESS. Any other input -> set STATUS.PERR, go IDLE, no access performed.
  - ACCESS: sel & !Penable -> SETUP (back-to-back transfer). Otherwise -> IDLE.
- Write commit: on the edge that leaves ACCESS, for transfers with Pwrite=1. Pwrite/Paddr/Pwdata are sampled at that edge.
- Read data: Prdata is loaded at the edge that enters ACCESS, for transfers with Pwrite=0.
  - Valid for the whole ACCESS cycle; held until the next read; unchanged by writes.
- Register map (word index = Paddr[5:2]):
  - 0 CTRL, RW: bit0 EN, bit1 IE; other bits read 0.
  - 1 STATUS, W1C: bit0 EXP, bit1 PERR.
  - 2 LOAD, RW, reload value.
  - 3 COUNT, RO; writes ignored.
  - 4..4+NUM_SCRATCH-1 SCRATCH, RW.
  - All other indices: read 0, writes ignored.
  - Paddr[1:0] and Paddr[31:6] are ignored.
- Timer:
  - CTRL.EN 0->1 write: COUNT <= LOAD on the commit edge.
  - EN=1 and COUNT!=0: COUNT decrements by 1 each cycle.
  - EN=1 and COUNT==0: COUNT <= LOAD and EXP <= 1 (expiry). With LOAD=0, expiry occurs every cycle.
  - EN=0: COUNT frozen.
  - LOAD write while running: takes effect at the next reload only.
- Simultaneous events:
  - Hardware set of EXP or PERR in the same cycle as a W1C of that bit: the set wins (bit stays 1).
  - COUNT read in the cycle it decrements: returns the pre-edge value.
- irq: registered, = STATUS.EXP & CTRL.IE, so it lags STATUS by one cycle. Clearing IE drops irq on the next cycle.
- Reset mid-transfer: async return to reset values; the transfer in flight has no effect.

Decomposition:
- Package apb_timer_pkg:
  - typedef enum apb_state_e {IDLE, SETUP, ACCESS}.
  - Register index localparams REG_CTRL=0, REG_STATUS=1, REG_LOAD=2, REG_COUNT=3, REG_SCRATCH0=4.
  - Bit positions CTRL_EN=0, CTRL_IE=1, ST_EXP=0, ST_PERR=1.
- One sub-module, apb_timer_core: the LOAD/COUNT/expiry logic.
  - Inputs: en, load value, load_now.
  - Outputs: count, expire pulse.
- APB FSM and register decode stay in the top module.

Test Plan:
- Reset then read every index 0..15 -> Prdata=0 at each ACCESS; irq=0.
- Write SCRATCH0 (Paddr=0x10) with 0xA5A5A5A5 and SCRATCH7 (0x2C) with 0x12345678, then read both back-to-back (SETUP directly after ACCESS) -> 0xA5A5A5A5, 0x12345678. Write to 0x3C then read -> 0.
- LOAD=5, CTRL=0x3 -> COUNT reads 5,4,..; EXP=1 six cycles after the EN commit; irq=1 one cycle later; COUNT reloads to 5.
- Write STATUS=0x1 on the exact cycle of a second expiry -> EXP stays 1. Write STATUS=0x1 with EN=0 -> EXP=0, irq=0 next cycle.
- Protocol errors: Penable=1 with sel while IDLE -> STATUS reads 0x2. Sel dropped during SETUP -> PERR set and no write committed (target scratch unchanged).
- Assert Hresetn=0 during the ACCESS phase of a write of 0xDEADBEEF to SCRATCH1 -> all outputs 0 immediately; after reset, SCRATCH1 reads 0.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// Shared types and register-map constants for the APB timer register bank.
package apb_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam logic [3:0] REG_CTRL     = 4'd0;
  localparam logic [3:0] REG_STATUS   = 4'd1;
  localparam logic [3:0] REG_LOAD     = 4'd2;
  localparam logic [3:0] REG_COUNT    = 4'd3;
  localparam logic [3:0] REG_SCRATCH0 = 4'd4;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;
  localparam int ST_EXP  = 0;
  localparam int ST_PERR = 1;

endpackage

// File: rtl/apb_timer_core.sv
// Reloadable down-counter: loads on enable rising, counts down while enabled,
// reloads and pulses expire_o (combinational, same cycle) when it reaches zero.
module apb_timer_core #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             load_now_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d  = count_q;
    expire_o = 1'b0;
    if (load_now_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      if (count_q == '0) begin
        count_d  = load_val_i;
        expire_o = 1'b1;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/apb_timer_regbank.sv
// Zero-wait-state APB slave: CTRL/STATUS/LOAD/COUNT/scratch registers, timer
// with level interrupt, and protocol-error capture into STATUS.PERR.
module apb_timer_regbank
  import apb_timer_pkg::*;
#(
  parameter int SEL_IDX     = 0,
  parameter int NUM_SCRATCH = 8,
  parameter int CNT_W       = 32
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        irq
);

  apb_state_e       state_q, state_d;
  logic [1:0]       ctrl_q, status_q, status_d;
  logic [CNT_W-1:0] load_q, count;
  logic [31:0]      scratch_q [NUM_SCRATCH];
  logic [31:0]      prdata_q, rdata;
  logic             irq_q;
  logic             sel, perr_set, wr_en, rd_en, expire, load_now;
  logic             wr_ctrl, wr_status, wr_load, scr_hit;
  logic [3:0]       idx, scr_off;
  logic             unused_ok;

  assign sel     = Pselx[SEL_IDX];
  assign idx     = Paddr[5:2];
  assign scr_off = idx - REG_SCRATCH0;
  assign scr_hit = (idx >= REG_SCRATCH0) && (int'(scr_off) < NUM_SCRATCH);

  always_comb begin
    state_d  = state_q;
    perr_set = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel) begin
          if (Penable) perr_set = 1'b1;
          else         state_d  = SETUP;
        end
      end
      SETUP: begin
        if (sel && Penable) begin
          state_d = ACCESS;
          rd_en   = !Pwrite;
        end else begin
          perr_set = 1'b1;
          state_d  = IDLE;
        end
      end
      ACCESS: begin
        // write data/address are taken from the bus on the edge leaving ACCESS
        wr_en   = Pwrite;
        state_d = (sel && !Penable) ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ctrl   = wr_en && (idx == REG_CTRL);
  assign wr_status = wr_en && (idx == REG_STATUS);
  assign wr_load   = wr_en && (idx == REG_LOAD);
  assign load_now  = wr_ctrl && Pwdata[CTRL_EN] && !ctrl_q[CTRL_EN];

  // hardware sets are applied after the W1C mask so they win a collision
  always_comb begin
    status_d = status_q;
    if (wr_status) status_d = status_q & ~Pwdata[1:0];
    if (expire)    status_d[ST_EXP]  = 1'b1;
    if (perr_set)  status_d[ST_PERR] = 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (idx)
      REG_CTRL:   rdata = {30'b0, ctrl_q};
      REG_STATUS: rdata = {30'b0, status_q};
      REG_LOAD:   rdata = 32'(load_q);
      REG_COUNT:  rdata = 32'(count);
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++)
          if (scr_hit && int'(scr_off) == i) rdata = scratch_q[i];
      end
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      status_q <= '0;
      load_q   <= '0;
      prdata_q <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      irq_q    <= status_q[ST_EXP] & ctrl_q[CTRL_IE];
      if (wr_ctrl) ctrl_q <= Pwdata[1:0];
      if (wr_load) load_q <= Pwdata[CNT_W-1:0];
      if (rd_en)   prdata_q <= rdata;
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (wr_en && scr_hit && int'(scr_off) == i) scratch_q[i] <= Pwdata;
    end
  end

  apb_timer_core #(.CNT_W(CNT_W)) u_core (
    .clk_i      (Hclk),
    .rst_ni     (Hresetn),
    .en_i       (ctrl_q[CTRL_EN]),
    .load_val_i (load_q),
    .load_now_i (load_now),
    .count_o    (count),
    .expire_o   (expire)
  );

  assign Prdata    = prdata_q;
  assign irq       = irq_q;
  assign unused_ok = ^{Paddr[31:6], Paddr[1:0], Pselx};

endmodule

// File: tb/tb_apb_timer_regbank.sv
// Bench for apb_timer_regbank: directed table, random register traffic against
// an address-map model, and timer/protocol/reset corner sequences.
module tb_apb_timer_regbank;
  localparam int NS = 8;

  logic        Hclk = 1'b0;
  logic        Hresetn = 1'b0;
  logic [2:0]  Pselx = 3'b000;
  logic        Penable = 1'b0, Pwrite = 1'b0;
  logic [31:0] Paddr = '0, Pwdata = '0;
  logic [31:0] Prdata;
  logic        irq;

  int n_chk = 0, n_pass = 0, edge_n = 0, t0 = 0;

  typedef struct {
    logic [31:0] wa, wd, ra, exp;
  } vec_t;
  vec_t tbl[10];
  logic [31:0] mdl[16];

  always #5 Hclk = ~Hclk;

  apb_timer_regbank #(.SEL_IDX(1), .NUM_SCRATCH(NS), .CNT_W(32)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // one bus cycle; the other slave selects toggle to prove they are ignored
  task automatic cyc(input bit s, input bit pe, input bit w, input logic [31:0] a, input logic [31:0] d);
    Pselx = s ? 3'b010 : 3'b101;
    Penable = pe; Pwrite = w; Paddr = a; Pwdata = d;
    @(posedge Hclk); #1;
    edge_n++;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1, 0, 1, a, d); cyc(1, 1, 1, a, d); cyc(0, 0, 1, a, d);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r, output int le);
    cyc(1, 0, 0, a, 32'h0); cyc(1, 1, 0, a, 32'h0);
    le = edge_n; r = Prdata;
    idle();
  endtask

  task automatic rd2(input logic [31:0] a1, input logic [31:0] a2, output logic [31:0] r1, output logic [31:0] r2);
    cyc(1, 0, 0, a1, 32'h0); cyc(1, 1, 0, a1, 32'h0); r1 = Prdata;
    cyc(1, 0, 0, a2, 32'h0); cyc(1, 1, 0, a2, 32'h0); r2 = Prdata;
    idle();
  endtask

  // LOAD=5 enabled at edge t0: period 6, count after edge e is 5 - (e-t0) mod 6
  function automatic logic [31:0] cnt_at(input int e);
    return 32'(5 - ((e - t0) % 6));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, r2, tmp;
    logic [3:0]  ix, ix2;
    int le, e, rr;

    tbl[0] = '{32'h00, 32'hFFFF_FFFE, 32'h00, 32'h0000_0002};
    tbl[1] = '{32'h08, 32'hCAFE_F00D, 32'h08, 32'hCAFE_F00D};
    tbl[2] = '{32'h0C, 32'h0000_1234, 32'h0C, 32'h0000_0000};
    tbl[3] = '{32'h10, 32'hA5A5_A5A5, 32'h10, 32'hA5A5_A5A5};
    tbl[4] = '{32'h2C, 32'h1234_5678, 32'h2C, 32'h1234_5678};
    tbl[5] = '{32'h3C, 32'hFFFF_FFFF, 32'h3C, 32'h0000_0000};
    tbl[6] = '{32'h30, 32'h0000_0001, 32'h30, 32'h0000_0000};
    tbl[7] = '{32'hFFFF_FF17, 32'h5555_AAAA, 32'h14, 32'h5555_AAAA};
    tbl[8] = '{32'h04, 32'hFFFF_FFFF, 32'h04, 32'h0000_0000};
    tbl[9] = '{32'h40, 32'h0000_0000, 32'h00, 32'h0000_0000};
    for (int i = 0; i < 16; i++) mdl[i] = '0;

    #12;
    check("rst_prdata", Prdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    @(negedge Hclk); Hresetn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      rd(32'(i * 4), r, le);
      check($sformatf("rst_read_idx%0d", i), r, 32'h0);
    end
    check("rst_irq_after", 32'(irq), 32'h0);

    // random traffic over LOAD, scratch and unmapped indices
    for (int n = 0; n < 40; n++) begin
      rr  = $urandom_range(0, 12);
      ix  = (rr == 0) ? 4'd2 : 4'(rr + 3);
      tmp = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom;
        wr({tmp[31:6], ix, tmp[1:0]}, r);
        if (ix == 4'd2 || int'(ix) < 4 + NS) mdl[ix] = r;
      end else begin
        rr  = $urandom_range(0, 12);
        ix2 = (rr == 0) ? 4'd2 : 4'(rr + 3);
        rd2({tmp[31:6], ix, tmp[1:0]}, {26'h0, ix2, 2'b00}, r, r2);
        check($sformatf("rand_rd_idx%0d", ix), r, mdl[ix]);
        check($sformatf("rand_rd2_idx%0d", ix2), r2, mdl[ix2]);
      end
    end

    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].wa, tbl[i].wd);
      rd(tbl[i].ra, r, le);
      check($sformatf("tbl%0d", i), r, tbl[i].exp);
    end

    rd2(32'h10, 32'h2C, r, r2);
    check("b2b_scratch0", r, 32'hA5A5_A5A5);
    check("b2b_scratch7", r2, 32'h1234_5678);
    wr(32'h3C, 32'h0000_FFFF);
    check("prdata_hold_on_write", Prdata, 32'h1234_5678);

    // timer: LOAD=5, enable with IE
    wr(32'h08, 32'd5);
    wr(32'h00, 32'h3);
    t0 = edge_n;
    for (int k = 0; k < 8; k++) begin
      idle();
      check("irq_rise", 32'(irq), 32'(edge_n >= t0 + 7));
    end
    for (int k = 0; k < 4; k++) begin
      rd(32'h0C, r, le);
      check("count_run", r, cnt_at(le - 1));
    end
    rd(32'h04, r, le);
    check("status_exp", r, 32'h1);

    // W1C landing exactly on an expiry edge
    e = t0 + 6;
    while (e < edge_n + 3) e += 6;
    while (edge_n < e - 3) idle();
    wr(32'h04, 32'h1);
    rd(32'h04, r, le);
    check("w1c_vs_expiry", r, 32'h1);
    check("irq_hold", 32'(irq), 32'h1);

    // W1C two cycles after an expiry, read back before the next one
    e = t0 + 6;
    while (e + 2 < edge_n + 3) e += 6;
    while (edge_n < e - 1) idle();
    wr(32'h04, 32'h1);
    rd(32'h04, r, le);
    check("w1c_clear_running", r, 32'h0);

    for (int k = 0; k < 8; k++) idle();
    wr(32'h00, 32'h2);
    e = edge_n;
    idle();
    check("irq_ie_on", 32'(irq), 32'h1);
    rd(32'h0C, r, le);
    check("count_frozen1", r, cnt_at(e));
    rd(32'h0C, r, le);
    check("count_frozen2", r, cnt_at(e));
    wr(32'h00, 32'h0);
    idle();
    check("irq_ie_off", 32'(irq), 32'h0);
    wr(32'h00, 32'h2);
    idle();
    check("irq_ie_again", 32'(irq), 32'h1);
    wr(32'h04, 32'h1);
    idle();
    check("irq_after_w1c", 32'(irq), 32'h0);
    rd(32'h04, r, le);
    check("status_cleared", r, 32'h0);

    // protocol errors
    cyc(1, 1, 0, 32'h04, 32'h0);
    idle();
    rd(32'h04, r, le);
    check("perr_enable_in_idle", r, 32'h2);
    wr(32'h04, 32'h2);
    rd(32'h04, r, le);
    check("perr_w1c", r, 32'h0);
    cyc(1, 0, 1, 32'h14, 32'hBAD0_BAD0);
    cyc(0, 0, 1, 32'h14, 32'hBAD0_BAD0);
    idle();
    rd(32'h14, r, le);
    check("setup_drop_no_write", r, 32'h5555_AAAA);
    rd(32'h04, r, le);
    check("perr_setup_drop", r, 32'h2);

    // reset during the ACCESS phase of a write
    rd(32'h10, r, le);
    check("pre_reset_prdata", r, 32'hA5A5_A5A5);
    cyc(1, 0, 1, 32'h14, 32'hDEAD_BEEF);
    cyc(1, 1, 1, 32'h14, 32'hDEAD_BEEF);
    Hresetn = 1'b0;
    #1;
    check("midrst_prdata", Prdata, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
    @(posedge Hclk);
    @(negedge Hclk); Hresetn = 1'b1;
    rd(32'h14, r, le);
    check("midrst_scratch1", r, 32'h0);
    rd(32'h08, r, le);
    check("midrst_load", r, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
